// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register slave.
// Provides the FSM state encoding and constant width functions.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Ceiling log2 usable in constant (parameter) context.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((32'sd1 <<< k) < v) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

    // Register index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between a requester and the register slave.
// Ports: psel/penable/pwrite/paddr/pwdata/pstrb in, prdata/pready/pslverr out.
interface apb_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter that paces access-phase wait states.
// Ports: clk_i, rst_i, load_i/load_val_i, dec_i in; zero_o out.
module apb_wait_ctr #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/apb_reg_slave.sv
// APB register file with wait states, byte strobes and RO hardware regs.
// Ports: pclk, preset, bus (APB slave), hw_in; reg_q, wr_en, rd_en, reg_idx.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                  ADDR_W      = 12,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    localparam int                 IDX_W       = idx_width(NUM_REGS)
) (
    input  logic                       pclk,
    input  logic                       preset,
    apb_if.slave                       bus,
    input  logic [NUM_REGS*DATA_W-1:0] hw_in,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic                       wr_en,
    output logic                       rd_en,
    output logic [IDX_W-1:0]           reg_idx
);
    localparam int NB  = DATA_W / 8;
    localparam int LSB = clog2(NB);

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              ctr_load, ctr_dec, ctr_zero;
    logic              done, fin;
    logic [ADDR_W-1:0] idx_full;
    logic              in_range, aligned, ro_hit, bad;
    logic [DATA_W-1:0] rd_val;

    apb_wait_ctr #(.W(4)) u_ctr (
        .clk_i      (pclk),
        .rst_i      (preset),
        .load_i     (ctr_load),
        .load_val_i (4'(WAIT_STATES)),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    // Decode works on the latched setup address.
    assign idx_full = addr_q >> LSB;
    assign in_range = idx_full < ADDR_W'(NUM_REGS);
    assign aligned  = (addr_q & ADDR_W'(NB - 1)) == '0;
    assign reg_idx  = idx_full[IDX_W-1:0];

    always_comb begin
        ro_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_full == ADDR_W'(i)) begin
                ro_hit = RO_MASK[i];
                rd_val = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end
    end

    assign bad = !in_range || !aligned || (write_q && ro_hit);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // penable without a setup cycle is ignored here.
                if (bus.psel && !bus.penable) begin
                    state_d  = ACCESS;
                    addr_d   = bus.paddr;
                    write_d  = bus.pwrite;
                    ctr_load = 1'b1;
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (bus.penable) begin
                    if (ctr_zero) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ctr_dec = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion is suppressed while reset is held.
    assign fin         = done && !preset;
    assign bus.pready  = fin;
    assign bus.pslverr = fin && bad;
    assign wr_en       = fin && !bad && write_q;
    assign rd_en       = fin && !bad && !write_q;
    assign bus.prdata  = rd_en ? rd_val : '0;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if ((idx_full == ADDR_W'(i)) && bus.pstrb[b]) begin
                        regs_q[i][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end
endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: two instances (0 and 3 wait states).
// Driver queues expected completions; a negedge monitor pops and compares.
module tb_apb_reg_slave;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam logic [NR-1:0] ROM = 8'h04;

    typedef struct {
        bit          wr;
        bit          err;
        logic [31:0] rdata;
        int          idx;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = '0;
    int            tgt = 0;

    apb_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    apb_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    assign bus0.psel    = psel && (tgt == 0);
    assign bus0.penable = penable;
    assign bus0.pwrite  = pwrite;
    assign bus0.paddr   = paddr;
    assign bus0.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;
    assign bus3.psel    = psel && (tgt == 3);
    assign bus3.penable = penable;
    assign bus3.pwrite  = pwrite;
    assign bus3.paddr   = paddr;
    assign bus3.pwdata  = pwdata;
    assign bus3.pstrb   = pstrb;

    logic [NR*DW-1:0] hw_in, rq0, rq3;
    logic [NR*DW-1:0] mm0 = '0, mm3 = '0;
    logic             wr0, rd0, wr3, rd3;
    logic [2:0]       ix0, ix3;

    apb_reg_slave #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR),
        .WAIT_STATES(0), .RO_MASK(ROM)
    ) dut0 (
        .pclk(pclk), .preset(preset), .bus(bus0), .hw_in(hw_in),
        .reg_q(rq0), .wr_en(wr0), .rd_en(rd0), .reg_idx(ix0)
    );

    apb_reg_slave #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR),
        .WAIT_STATES(3), .RO_MASK(ROM)
    ) dut3 (
        .pclk(pclk), .preset(preset), .bus(bus3), .hw_in(hw_in),
        .reg_q(rq3), .wr_en(wr3), .rd_en(rd3), .reg_idx(ix3)
    );

    logic        s_rdy, s_err, s_wr, s_rd;
    logic [31:0] s_rdata;
    logic [2:0]  s_idx;
    assign s_rdy   = (tgt == 3) ? bus3.pready  : bus0.pready;
    assign s_err   = (tgt == 3) ? bus3.pslverr : bus0.pslverr;
    assign s_rdata = (tgt == 3) ? bus3.prdata  : bus0.prdata;
    assign s_wr    = (tgt == 3) ? wr3 : wr0;
    assign s_rd    = (tgt == 3) ? rd3 : rd0;
    assign s_idx   = (tgt == 3) ? ix3 : ix0;

    always @(negedge pclk) begin
        if (preset) begin
            if (bus0.pready || bus3.pready || bus0.pslverr || bus3.pslverr ||
                wr0 || rd0 || wr3 || rd3 ||
                (bus0.prdata != 0) || (bus3.prdata != 0)) begin
                nvec++;
                nerr++;
                $display("FAIL reset_quiet outputs active during reset");
            end
        end else if (s_rdy) begin
            nvec++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_pready tgt=%0d", tgt);
            end else begin
                exp_t e;
                bit   ew, er, bad;
                e  = q.pop_front();
                ew = e.wr && !e.err;
                er = !e.wr && !e.err;
                bad = (s_err !== e.err) || (s_wr !== ew) || (s_rd !== er) ||
                      (s_rdata !== e.rdata) ||
                      (!e.err && (int'(s_idx) != e.idx));
                if (bad) begin
                    nerr++;
                    $display("FAIL completion tgt=%0d got err=%b wr=%b rd=%b rdata=%h idx=%0d required err=%b wr=%b rd=%b rdata=%h idx=%0d",
                             tgt, s_err, s_wr, s_rd, s_rdata, s_idx,
                             e.err, ew, er, e.rdata, e.idx);
                end
            end
        end else if (s_wr || s_rd || (bus0.pready && tgt != 0) ||
                     (bus3.pready && tgt != 3)) begin
            nvec++;
            nerr++;
            $display("FAIL stray_pulse tgt=%0d wr=%b rd=%b", tgt, s_wr, s_rd);
        end
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %h required %h", nm, act, exp);
        end
    endtask

    task automatic xfer(input int t, input bit wr, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input bit err, input logic [31:0] erd,
                        input int ews, input string nm);
        exp_t e;
        int   w;
        bit   got;
        int   ix;
        ix      = int'(a >> 2);
        e.wr    = wr;
        e.err   = err;
        e.rdata = (wr || err) ? 32'h0 : erd;
        e.idx   = ix;
        q.push_back(e);
        @(posedge pclk);
        #1;
        tgt = t; psel = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        w = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge pclk);
            if (s_rdy) got = 1'b1;
            else w++;
        end
        nvec++;
        if (!got) begin
            nerr++;
            $display("FAIL %s pready timeout", nm);
            void'(q.pop_back());
        end else if (w != ews) begin
            nerr++;
            $display("FAIL %s wait cycles got %0d required %0d", nm, w, ews);
        end
        if (got && wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    if (t == 0) mm0[ix*32 + b*8 +: 8] = d[b*8 +: 8];
                    else        mm3[ix*32 + b*8 +: 8] = d[b*8 +: 8];
                end
            end
        end
    endtask

    task automatic idle();
        @(posedge pclk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
    endtask

    task automatic chk_regs(input string nm);
        @(negedge pclk);
        chk({nm, "_rq0"}, rq0, mm0);
        chk({nm, "_rq3"}, rq3, mm3);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            hw_in[i*32 +: 32] = 32'h5555_0000 + i;
        end
        hw_in[2*32 +: 32] = 32'hCAFE_0001;

        repeat (3) @(negedge pclk);
        chk("rst_pready0", {255'b0, bus0.pready}, 256'b0);
        chk("rst_pready3", {255'b0, bus3.pready}, 256'b0);
        chk("rst_rq0", rq0, 256'b0);
        chk("rst_rq3", rq3, 256'b0);
        @(posedge pclk);
        #1;
        preset = 1'b0;

        xfer(0, 1, 12'h004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "ws0_wr");
        idle();
        chk_regs("ws0_wr");
        chk("ws0_word1", {224'b0, rq0[63:32]}, {224'b0, 32'hDEAD_BEEF});

        xfer(3, 1, 12'h004, 32'hDEAD_BEEF, 4'hF, 0, 0, 3, "ws3_wr");
        xfer(3, 0, 12'h004, 0, 4'h0, 0, 32'hDEAD_BEEF, 3, "ws3_rd");
        idle();

        xfer(0, 1, 12'h004, 32'h1122_3344, 4'h5, 0, 0, 0, "strb5_wr");
        xfer(0, 0, 12'h004, 0, 4'h0, 0, 32'hDE22_BE44, 0, "strb5_rd");
        idle();
        chk("strb5_word1", {224'b0, rq0[63:32]}, {224'b0, 32'hDE22_BE44});

        xfer(0, 1, 12'h020, 32'h0BAD_0BAD, 4'hF, 1, 0, 0, "idx8_wr");
        xfer(0, 1, 12'h006, 32'h0BAD_0BAD, 4'hF, 1, 0, 0, "misal_wr");
        idle();
        chk_regs("err_wr");

        xfer(0, 0, 12'h008, 0, 4'h0, 0, 32'hCAFE_0001, 0, "ro_rd0");
        xfer(0, 1, 12'h008, 32'h1234_5678, 4'hF, 1, 0, 0, "ro_wr0");
        xfer(3, 0, 12'h008, 0, 4'h0, 0, 32'hCAFE_0001, 3, "ro_rd3");
        xfer(3, 0, 12'h020, 0, 4'h0, 1, 0, 3, "oob_rd3");
        idle();
        chk_regs("ro");

        xfer(0, 1, 12'h00C, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, "b2b_wr");
        xfer(0, 0, 12'h00C, 0, 4'h0, 0, 32'hA5A5_5A5A, 0, "b2b_rd");
        xfer(0, 1, 12'h01C, 32'hFFFF_FF77, 4'h1, 0, 0, 0, "b2b_wr7");
        xfer(0, 0, 12'h01C, 0, 4'h0, 0, 32'h0000_0077, 0, "b2b_rd7");
        idle();
        chk_regs("b2b");

        @(posedge pclk);
        #1;
        tgt = 3; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 12'h010; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        repeat (6) begin
            @(negedge pclk);
            chk("nosetup_pready", {255'b0, bus3.pready}, 256'b0);
        end
        idle();
        chk_regs("nosetup");

        @(posedge pclk);
        #1;
        tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h00C; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(posedge pclk);
        #1;
        psel = 1'b0;
        repeat (2) @(negedge pclk);
        chk_regs("drop0");

        @(posedge pclk);
        #1;
        tgt = 3; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h00C; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
        repeat (2) @(negedge pclk);
        chk_regs("drop3");
        xfer(3, 0, 12'h00C, 0, 4'h0, 0, 32'h0, 3, "after_drop3");
        idle();

        @(posedge pclk);
        #1;
        tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h010; pwdata = 32'h7777_7777; pstrb = 4'hF;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        preset = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
        preset = 1'b0;
        mm0 = '0;
        mm3 = '0;
        chk_regs("rst_mid");

        xfer(0, 0, 12'h010, 0, 4'h0, 0, 32'h0, 0, "post_rst_rd0");
        xfer(3, 1, 12'h010, 32'h0102_0304, 4'hF, 0, 0, 3, "post_rst_wr3");
        xfer(3, 0, 12'h010, 0, 4'h0, 0, 32'h0102_0304, 3, "post_rst_rd3");
        idle();
        chk_regs("final");

        repeat (2) @(negedge pclk);
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_W, 12, paddr width in bits.
REQ-002 SHALL have parameter DATA_W, 32, data width in bits; legal values are 8, 16 and 32.
REQ-003 SHALL have parameter NUM_REGS, 8, number of registers; legal range is 1 to 2^(ADDR_W-log2(DATA_W/8)).
REQ-004 SHALL have parameter WAIT_STATES, 0, access-phase wait cycles before pready; legal range is 0 to 15.
REQ-005 SHALL have parameter RO_MASK, 0, one bit per register; a 1 marks that register read-only and hardware-sourced.
REQ-006 SHALL have port pclk  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port preset  input  1  reset, synchronous and active-high.
REQ-008 SHALL have ports psel, penable, pwrite  input  1 each  APB control.
REQ-009 SHALL have port paddr  input  ADDR_W  byte address.
REQ-010 SHALL have port pwdata  input  DATA_W  write data.
REQ-011 SHALL have port pstrb  input  DATA_W/8  byte-lane write strobes.
REQ-012 SHALL have port prdata  output  DATA_W  read data.
REQ-013 SHALL have port pready  output  1  transfer complete.
REQ-014 SHALL have port pslverr  output  1  transfer error.
REQ-015 SHALL have port hw_in  input  NUM_REGS*DATA_W  read values for RO registers.
REQ-016 SHALL have port reg_q  output  NUM_REGS*DATA_W  register contents; register i occupies slice [i*DATA_W +: DATA_W].
REQ-017 SHALL have ports wr_en, rd_en  output  1 each  single-cycle transfer-commit pulses.
REQ-018 SHALL have port reg_idx  output  log2(NUM_REGS), minimum 1  index of the register being committed.

Function
REQ-019 SHALL compute register index as paddr >> log2(DATA_W/8).
REQ-020 SHALL flag a transfer invalid on any of: index >= NUM_REGS; paddr low bits not word-aligned; write to a register whose RO_MASK bit is set.
REQ-021 SHALL implement a two-state FSM: IDLE goes to ACCESS on (psel & !penable), loading wait counter cnt with WAIT_STATES and latching paddr and pwrite.
REQ-022 SHALL, in ACCESS with psel & penable, decrement cnt while cnt != 0.
REQ-023 SHALL, in ACCESS with psel & penable and cnt == 0, assert pready combinationally and return to IDLE on the next edge.
REQ-024 SHALL therefore give exactly WAIT_STATES access-phase wait cycles; with WAIT_STATES = 0, pready is high in the first access cycle.
REQ-025 SHALL, if psel drops while in ACCESS, abort to IDLE with no commit, no pulse and no pready.
REQ-026 SHALL, in IDLE, ignore penable high without a preceding setup cycle: pready stays 0 and the FSM stays IDLE.
REQ-027 SHALL, in the pready cycle of an invalid transfer, drive pslverr = 1; otherwise pslverr = 0.
REQ-028 SHALL make pslverr a completion cycle with no register update.
REQ-029 SHALL drive prdata, in the pready cycle of a valid read, with reg_q (RW registers) or the hw_in slice (RO registers); prdata is 0 in all other cycles.
REQ-030 SHALL, in the pready cycle of a valid write, update only the byte lanes with pstrb set; the new value is visible on reg_q the next cycle.
REQ-031 SHALL pulse wr_en or rd_en for exactly one cycle, coincident with pready of a valid transfer, with reg_idx valid in that cycle.
REQ-032 SHALL accept back-to-back transfers: a setup phase in the cycle after pready is accepted with no idle cycle.

Reset
REQ-033 SHALL, with preset high at a clock edge, force FSM = IDLE, cnt = 0 and all registers to 0.
REQ-034 SHALL hold pready, pslverr, wr_en and rd_en at 0, and prdata at 0, during reset.
REQ-035 SHALL, on reset asserted mid-transfer, abandon the transfer with no partial write.

Structure
REQ-036 SHALL place the FSM state encoding and the helper width function (clog2) in shared package apb_pkg.
REQ-037 SHALL use one sub-module, apb_wait_ctr, for the loadable down-counter and its zero flag.

Verification
REQ-038 SHALL cover: WAIT_STATES = 0, write 0xDEADBEEF to 0x004 with pstrb = 0xF -> pready in the first access cycle; wr_en pulse with reg_idx = 1; reg_q[1] = 0xDEADBEEF.
REQ-039 SHALL cover: WAIT_STATES = 3, read 0x004 -> 3 access cycles with pready low, then pready with prdata = 0xDEADBEEF and an rd_en pulse.
REQ-040 SHALL cover: write 0x11223344 to 0x004 with pstrb = 0x5 -> reg_q[1] = 0xDE22BE44.
REQ-041 SHALL cover: write to 0x020 (index 8) and to 0x006 (misaligned) -> pslverr = 1 with pready; no wr_en; all reg_q unchanged.
REQ-042 SHALL cover: RO_MASK = 0x04 with hw_in[2] = 0xCAFE0001 -> read 0x008 returns 0xCAFE0001; write 0x008 returns pslverr.
REQ-043 SHALL cover: psel dropped in ACCESS, and preset asserted mid-write -> FSM returns to IDLE, no pulse, registers unchanged (0 after reset).
